fsm_checker: RTL and testbench
==============================

// Module: fsm_checker
// PURPOSE
//  Post-decryption plaintext checker for the RC4 key-search datapath.
//  - On a start pulse, reads the decrypted message RAM (D) byte by byte.
//  - Each byte must be a lowercase letter 'a'..'z' (0x61-0x7A) or a space (0x20).
//  - Reports whether the whole message is plausible plaintext; the key-search controller uses the result to accept or reject the current key.
// PARAMETERS
//  MSG_LEN  32  number of message bytes checked, at addresses 0..MSG_LEN-1
//  ADDR_W   8   width of Address; MSG_LEN <= 2**ADDR_W
// PORTS
//  CLOCK_50        in   1       system clock, rising edge
//  rst             in   1       synchronous, active-high reset
//  Checker_Start   in   1       start request; sampled only in IDLE; a 1-cycle pulse is sufficient
//  Finish_ack      in   1       acknowledge of Checker_Finish; returns the FSM to IDLE
//  q_D             in   8       read data from message RAM D; 1-cycle read latency
//  Checker_Finish  out  1       high for the whole DONE state, until acknowledged
//  Address         out  ADDR_W  read address into message RAM D
//  Decrypt_Valid   out  1       1 = every byte passed the check; meaningful while Checker_Finish=1
// BEHAVIOUR
//  Clock and reset
//  - Single clock domain, CLOCK_50.
//  - rst is synchronous and active-high: state<=IDLE, idx<=0, Address=0, Checker_Finish=0, Decrypt_Valid=0.
//  - rst asserted mid-scan aborts the scan immediately; no Finish is reported for the aborted scan.
//  State machine
//  - States: IDLE, READ, WAIT, CHECK, DONE.
//  - All outputs are registered or decoded from state/idx only; none depends combinationally on q_D.
//  - Address = idx at all times.
//  - IDLE: if Checker_Start, then idx<=0, Decrypt_Valid<=0, and go to READ. Otherwise stay.
//  - READ: Address is presented to the RAM. Go to WAIT.
//  - WAIT: RAM latency cycle. Go to CHECK.
//  - CHECK: sample q_D.
//    - Byte valid iff (q_D>=8'h61 && q_D<=8'h7A) || q_D==8'h20.
//    - Invalid byte: Decrypt_Valid<=0 and go to DONE (early abort).
//    - Valid byte with idx==MSG_LEN-1: Decrypt_Valid<=1 and go to DONE.
//    - Valid byte otherwise: idx<=idx+1 and go to READ.
//  - DONE: Checker_Finish=1; Decrypt_Valid holds the verdict. Stay until Finish_ack=1, then go to IDLE.
//  Timing
//  - 3 cycles per byte.
//  - Count from the edge that samples Checker_Start. Byte n is judged in CHECK and DONE is entered on edge 3n+3.
//  - A fully valid message enters DONE on edge 3*MSG_LEN (96 with defaults).
//  Boundaries and simultaneous events
//  - Boundary bytes 0x60 '`', 0x7B '{', 0x40 '@', 0x41 'A' and 0x00 are invalid.
//  - Boundary bytes 0x61, 0x7A and 0x20 are valid.
//  - Checker_Start outside IDLE is ignored, including in DONE.
//  - Finish_ack outside DONE is ignored.
//  - Checker_Start held high through DONE: a new scan starts on the first IDLE cycle after the ack.
//  - Decrypt_Valid keeps its verdict in IDLE and is cleared only by the next start or by rst.
//  - idx never exceeds MSG_LEN-1; there is no address wrap.
// STRUCTURE
//  - Shared package (checker_pkg): state enum; constants CHAR_A=8'h61, CHAR_Z=8'h7A, CHAR_SPACE=8'h20; default MSG_LEN.
//  - One natural sub-module, char_is_valid: combinational, 8-bit in, 1-bit out. Reusable by other checkers.
//  - Everything else stays in a single FSM process plus the idx register.
// TESTING
//  - All-valid scan: RAM model holds 'a'..'z' plus spaces (32 bytes); pulse Start.
//    -> Address steps 0..31, each held for 3 cycles.
//    -> Checker_Finish=1 and Decrypt_Valid=1 at edge 96; both hold until Finish_ack.
//  - Early abort: byte 3 = '2' (0x32), all other bytes 'f'.
//    -> DONE at edge 12 with Decrypt_Valid=0.
//    -> Address never exceeds 3.
//  - Character boundaries, one byte under test per run at address 5, all other bytes valid.
//    -> '`', '{', 'A' and 0x00 each give Decrypt_Valid=0.
//    -> 'a', 'z' and ' ' each give Decrypt_Valid=1.
//  - Handshake: hold Finish_ack low for 10 cycles.
//    -> Checker_Finish stays 1.
//    -> Ack pulse -> Checker_Finish=0 the next cycle; Decrypt_Valid keeps its verdict.
//    -> Next Start clears Decrypt_Valid.
//  - Ignored start: pulse Start again mid-scan.
//    -> No restart; idx continues from its current value.
//  - Reset mid-scan: assert rst at edge 20.
//    -> Next cycle: IDLE, Address=0, Checker_Finish=0, Decrypt_Valid=0.
//    -> A fresh Start then completes normally.

Source files
------------

// File: rtl/checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : checker_pkg
// Description : Shared types and character constants for plaintext checkers.
// Revision    : 1.0 - initial release
// ============================================================================
package checker_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] CHAR_A          = 8'h61;
    localparam logic [7:0] CHAR_Z          = 8'h7A;
    localparam logic [7:0] CHAR_SPACE      = 8'h20;
    localparam int         DEFAULT_MSG_LEN = 32;

endpackage : checker_pkg
`default_nettype wire

// File: rtl/char_is_valid.sv
`default_nettype none
// ============================================================================
// Module      : char_is_valid
// Description : Flags a byte as plausible plaintext (lowercase letter or space).
// Revision    : 1.0 - initial release
// ============================================================================
module char_is_valid
    import checker_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_valid
);

    assign o_valid = ((i_byte >= CHAR_A) && (i_byte <= CHAR_Z)) || (i_byte == CHAR_SPACE);

endmodule : char_is_valid
`default_nettype wire

// File: rtl/fsm_checker.sv
`default_nettype none
// ============================================================================
// Module      : fsm_checker
// Description : Scans decrypted message RAM and reports whether every byte is
//               plausible plaintext. Three cycles per byte, early abort.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_checker
    import checker_pkg::*;
#(
    parameter int MSG_LEN = DEFAULT_MSG_LEN,
    parameter int ADDR_W  = 8
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              Checker_Start,
    input  logic              Finish_ack,
    input  logic [7:0]        q_D,
    output logic              Checker_Finish,
    output logic [ADDR_W-1:0] Address,
    output logic              Decrypt_Valid
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(MSG_LEN - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_next;
    logic              r_valid;
    logic              w_valid_next;
    logic              w_byte_ok;

    char_is_valid u_char_is_valid (
        .i_byte  (q_D),
        .o_valid (w_byte_ok)
    );

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_valid_next = r_valid;
        unique case (r_state)
            S_IDLE: begin
                if (Checker_Start) begin
                    w_idx_next   = '0;
                    w_valid_next = 1'b0;
                    w_state_next = S_READ;
                end
            end
            S_READ:  w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_CHECK;
            S_CHECK: begin
                // q_D now reflects the address presented in READ
                if (!w_byte_ok) begin
                    w_valid_next = 1'b0;
                    w_state_next = S_DONE;
                end else if (r_idx == c_LAST_IDX) begin
                    w_valid_next = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_idx_next   = r_idx + ADDR_W'(1);
                    w_state_next = S_READ;
                end
            end
            S_DONE: begin
                if (Finish_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign Address        = r_idx;
    assign Checker_Finish = (r_state == S_DONE);
    assign Decrypt_Valid  = r_valid;

endmodule : fsm_checker
`default_nettype wire

// File: tb/tb_fsm_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_checker
// Description : Self-checking bench for fsm_checker with a 1-cycle RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_checker;

    logic       CLOCK_50 = 1'b0;
    logic       rst;
    logic       Checker_Start;
    logic       Finish_ack;
    logic [7:0] q_D;
    logic       Checker_Finish;
    logic [7:0] Address;
    logic       Decrypt_Valid;

    logic [7:0] mem [32];
    int         tests = 0;
    int         fails = 0;
    bit         exp_q [$];

    typedef struct {
        logic [7:0] chr;
        bit         exp_valid;
    } vec_t;
    vec_t vecs [8];

    fsm_checker #(.MSG_LEN(32), .ADDR_W(8)) dut (
        .CLOCK_50       (CLOCK_50),
        .rst            (rst),
        .Checker_Start  (Checker_Start),
        .Finish_ack     (Finish_ack),
        .q_D            (q_D),
        .Checker_Finish (Checker_Finish),
        .Address        (Address),
        .Decrypt_Valid  (Decrypt_Valid)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) q_D <= (Address < 8'd32) ? mem[Address[4:0]] : 8'hFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input logic [7:0] b);
        for (int i = 0; i < 32; i++) mem[i] = b;
    endtask

    // Pulse start, run to DONE, compare latency, address trace and verdict.
    // poke_edge drives Start and Finish_ack for one edge mid-scan (0 = never).
    task automatic scan(input string name, input int exp_edge, input bit exp_valid,
                        input int poke_edge);
        int k;
        bit addr_ok = 1'b1;
        exp_q.push_back(exp_valid);
        Checker_Start = 1'b1;
        @(posedge CLOCK_50); #1;
        Checker_Start = 1'b0;
        check({name, "_clear"}, Decrypt_Valid, 0);
        for (k = 1; k <= 400; k++) begin
            Checker_Start = (k == poke_edge);
            Finish_ack    = (k == poke_edge);
            @(posedge CLOCK_50); #1;
            if (Checker_Finish) break;
            if (Address !== 8'(k / 3)) addr_ok = 1'b0;
        end
        Checker_Start = 1'b0;
        Finish_ack    = 1'b0;
        check({name, "_done_edge"}, k, exp_edge);
        check({name, "_addr_trace"}, addr_ok, 1);
        check({name, "_last_addr"}, Address, exp_edge / 3 - 1);
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s_scoreboard: got empty queue expected entry", name);
        end else begin
            check({name, "_verdict"}, Decrypt_Valid, exp_q.pop_front());
        end
    endtask

    task automatic ack(input string name, input bit exp_valid);
        Finish_ack = 1'b1;
        @(posedge CLOCK_50); #1;
        Finish_ack = 1'b0;
        check({name, "_ack_finish"}, Checker_Finish, 0);
        check({name, "_ack_keep"}, Decrypt_Valid, exp_valid);
    endtask

    initial begin
        bit hold_ok;
        vecs[0] = '{8'h60, 1'b0};
        vecs[1] = '{8'h7B, 1'b0};
        vecs[2] = '{8'h41, 1'b0};
        vecs[3] = '{8'h00, 1'b0};
        vecs[4] = '{8'h40, 1'b0};
        vecs[5] = '{8'h61, 1'b1};
        vecs[6] = '{8'h7A, 1'b1};
        vecs[7] = '{8'h20, 1'b1};

        rst = 1'b1; Checker_Start = 1'b0; Finish_ack = 1'b0;
        fill(8'h66);
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_addr", Address, 0);
        check("rst_finish", Checker_Finish, 0);
        check("rst_valid", Decrypt_Valid, 0);
        rst = 1'b0;
        @(posedge CLOCK_50); #1;

        for (int i = 0; i < 32; i++) mem[i] = (i < 26) ? 8'(8'h61 + i) : 8'h20;
        scan("all_valid", 96, 1'b1, 0);

        // Start held through DONE must not restart the scan.
        hold_ok = 1'b1;
        Checker_Start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLOCK_50); #1;
            if (!Checker_Finish || !Decrypt_Valid || Address !== 8'd31) hold_ok = 1'b0;
        end
        Checker_Start = 1'b0;
        check("hold_done", hold_ok, 1);
        ack("all_valid", 1'b1);
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("idle_keep_verdict", Decrypt_Valid, 1);

        fill(8'h66);
        mem[3] = 8'h32;
        scan("abort", 12, 1'b0, 0);
        ack("abort", 1'b0);

        for (int v = 0; v < 8; v++) begin
            fill(8'h66);
            mem[5] = vecs[v].chr;
            scan($sformatf("chr_%02h", vecs[v].chr), vecs[v].exp_valid ? 96 : 18,
                 vecs[v].exp_valid, 0);
            ack($sformatf("chr_%02h", vecs[v].chr), vecs[v].exp_valid);
        end

        fill(8'h20);
        scan("ignored_start", 96, 1'b1, 40);
        ack("ignored_start", 1'b1);

        fill(8'h7A);
        Checker_Start = 1'b1;
        @(posedge CLOCK_50); #1;
        Checker_Start = 1'b0;
        repeat (19) @(posedge CLOCK_50);
        #1;
        rst = 1'b1;
        @(posedge CLOCK_50); #1;
        rst = 1'b0;
        check("midrst_addr", Address, 0);
        check("midrst_finish", Checker_Finish, 0);
        check("midrst_valid", Decrypt_Valid, 0);
        repeat (5) @(posedge CLOCK_50);
        #1;
        check("midrst_stay_idle", {Checker_Finish, Address}, 0);
        scan("after_rst", 96, 1'b1, 0);
        ack("after_rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fsm_checker
`default_nettype wire
